// File: rtl/seq_data_checker.sv
// seq_data_checker: receive-side checker for incrementing-sequence test streams.
// It locks onto the first word it accepts and then expects each later word to be the previous word + 1.
// It reports a pulse for each mismatched word, a pulse on loss of lock, and saturating word/error counters.
// Build option: define SEQ_CHK_ERR_CAPTURE_EN to latch the expected and received values of the first error.
// Without that macro, O_firstErrExp and O_firstErrRcv are tied to 0.
module seq_data_checker #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_CNT_WIDTH  = 32,
  parameter int C_LOSS_NUM   = 4
) (
  input  logic                    I_clk,
  input  logic                    I_rstn,
  input  logic                    I_chkEn,
  input  logic                    I_clr,
  output logic                    O_rReady,
  input  logic                    I_dataEn,
  input  logic [C_DATA_WIDTH-1:0] I_data,
  output logic                    O_locked,
  output logic                    O_errFlg,
  output logic                    O_lossFlg,
  output logic [C_CNT_WIDTH-1:0]  O_wordCnt,
  output logic [C_CNT_WIDTH-1:0]  O_errCnt,
  output logic [C_DATA_WIDTH-1:0] O_firstErrExp,
  output logic [C_DATA_WIDTH-1:0] O_firstErrRcv
);

  localparam int C_CONSEC_W = $clog2(C_LOSS_NUM + 1);
  localparam logic [C_CONSEC_W-1:0] C_LOSS_VAL = C_CONSEC_W'(C_LOSS_NUM);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                  state;
  logic [C_DATA_WIDTH-1:0] expVal;
  logic [C_CONSEC_W-1:0]   consecErr;
  logic [C_CONSEC_W-1:0]   consecNext;
  logic                    accept;
  logic [C_DATA_WIDTH-1:0] dataNext;

  // A word moves only when the buffer offers it and this side has advertised ready.
  assign accept     = I_dataEn && O_rReady;
  assign dataNext   = I_data + C_DATA_WIDTH'(1);
  assign consecNext = consecErr + C_CONSEC_W'(1);

  // Statistic counters stick at all-ones rather than wrapping back to a small value.
  function automatic logic [C_CNT_WIDTH-1:0] satInc(input logic [C_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + C_CNT_WIDTH'(1);
  endfunction

  // Lock/check FSM with registered flags, counters and ready.
  // NOTE: all state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state     <= IDLE;
      expVal    <= '0;
      consecErr <= '0;
      O_rReady  <= 1'b0;
      O_locked  <= 1'b0;
      O_errFlg  <= 1'b0;
      O_lossFlg <= 1'b0;
      O_wordCnt <= '0;
      O_errCnt  <= '0;
    end else begin
      O_rReady  <= I_chkEn;
      O_errFlg  <= 1'b0;
      O_lossFlg <= 1'b0;
      if (I_clr) begin
        state     <= IDLE;
        expVal    <= '0;
        consecErr <= '0;
        O_locked  <= 1'b0;
        O_wordCnt <= '0;
        O_errCnt  <= '0;
      end else if (accept) begin
        expVal <= dataNext;
        unique case (state)
          IDLE: begin
            state     <= LOCK;
            O_locked  <= 1'b1;
            O_wordCnt <= C_CNT_WIDTH'(1);
            consecErr <= '0;
          end
          LOCK: begin
            O_wordCnt <= satInc(O_wordCnt);
            if (I_data == expVal) begin
              consecErr <= '0;
            end else begin
              // Realigning to the received word means one dropped word costs exactly one error.
              O_errFlg <= 1'b1;
              O_errCnt <= satInc(O_errCnt);
              if (consecNext == C_LOSS_VAL) begin
                O_lossFlg <= 1'b1;
                O_locked  <= 1'b0;
                state     <= IDLE;
                consecErr <= '0;
              end else begin
                consecErr <= consecNext;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SEQ_CHK_ERR_CAPTURE_EN
  logic                    errCaptured;
  logic [C_DATA_WIDTH-1:0] capExp;
  logic [C_DATA_WIDTH-1:0] capRcv;
  logic                    mismatchHit;

  assign mismatchHit = accept && !I_clr && (state == LOCK) && (I_data != expVal);

  // Latch the first error after reset or clear; hold through loss of lock and relock.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      errCaptured <= 1'b0;
      capExp      <= '0;
      capRcv      <= '0;
    end else if (I_clr) begin
      errCaptured <= 1'b0;
      capExp      <= '0;
      capRcv      <= '0;
    end else if (mismatchHit && !errCaptured) begin
      errCaptured <= 1'b1;
      capExp      <= expVal;
      capRcv      <= I_data;
    end
  end

  assign O_firstErrExp = capExp;
  assign O_firstErrRcv = capRcv;
`else
  assign O_firstErrExp = '0;
  assign O_firstErrRcv = '0;
`endif

endmodule

// File: tb/tb_seq_data_checker.sv
// tb_seq_data_checker: scoreboard bench for seq_data_checker.
// Each driven cycle pushes a reference-model prediction into a queue.
// That prediction is popped and compared against the DUT one cycle later.
`timescale 1ns/1ps
module tb_seq_data_checker;
  localparam int DW   = 32;
  localparam int CW   = 32;
  localparam int LOSS = 4;

  logic          sim_clk = 1'b0;
  logic          rstn, chkEn, clr, dataEn;
  logic [DW-1:0] data;
  logic          rReady, locked, errFlg, lossFlg;
  logic [CW-1:0] wordCnt, errCnt;
  logic [DW-1:0] firstErrExp, firstErrRcv;

  always #5 sim_clk = ~sim_clk;

  seq_data_checker #(.C_DATA_WIDTH(DW), .C_CNT_WIDTH(CW), .C_LOSS_NUM(LOSS)) dut (
    .I_clk(sim_clk), .I_rstn(rstn), .I_chkEn(chkEn), .I_clr(clr),
    .O_rReady(rReady), .I_dataEn(dataEn), .I_data(data),
    .O_locked(locked), .O_errFlg(errFlg), .O_lossFlg(lossFlg),
    .O_wordCnt(wordCnt), .O_errCnt(errCnt),
    .O_firstErrExp(firstErrExp), .O_firstErrRcv(firstErrRcv)
  );

  typedef struct packed {
    logic          ready;
    logic          locked;
    logic          errFlg;
    logic          lossFlg;
    logic [CW-1:0] wordCnt;
    logic [CW-1:0] errCnt;
    logic [DW-1:0] fExp;
    logic [DW-1:0] fRcv;
  } obs_t;

  obs_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   errPulses = 0;
  int   lossPulses = 0;

  // reference model state
  logic          mReady, mLocked, mCap;
  logic [DW-1:0] mExp, mCapExp, mCapRcv;
  logic [CW-1:0] mWord, mErr;
  int            mConsec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1;
  endfunction

  task automatic modelZero(input logic keepReady);
    if (!keepReady) mReady = 1'b0;
    mLocked = 1'b0; mCap = 1'b0; mExp = '0; mCapExp = '0; mCapRcv = '0;
    mWord = '0; mErr = '0; mConsec = 0;
  endtask

  task automatic compareAll(input obs_t e);
    check("rReady",  64'(rReady),  64'(e.ready));
    check("locked",  64'(locked),  64'(e.locked));
    check("errFlg",  64'(errFlg),  64'(e.errFlg));
    check("lossFlg", 64'(lossFlg), 64'(e.lossFlg));
    check("wordCnt", 64'(wordCnt), 64'(e.wordCnt));
    check("errCnt",  64'(errCnt),  64'(e.errCnt));
    check("fErrExp", 64'(firstErrExp), 64'(e.fExp));
    check("fErrRcv", 64'(firstErrRcv), 64'(e.fRcv));
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare after the edge.
  task automatic step(input logic en, input logic [DW-1:0] d, input logic c, input logic chk);
    obs_t e;
    logic acc;
    dataEn = en; data = d; clr = c; chkEn = chk;
    acc = en && mReady;
    e = '0;
    if (c) begin
      modelZero(1'b1);
    end else if (acc) begin
      if (!mLocked) begin
        mLocked = 1'b1; mWord = 1; mConsec = 0;
      end else if (d == mExp) begin
        mWord = sat(mWord); mConsec = 0;
      end else begin
        e.errFlg = 1'b1;
        mErr = sat(mErr); mWord = sat(mWord);
        if (!mCap) begin mCap = 1'b1; mCapExp = mExp; mCapRcv = d; end
        mConsec++;
        if (mConsec == LOSS) begin e.lossFlg = 1'b1; mLocked = 1'b0; mConsec = 0; end
      end
      mExp = d + 1;
    end
    mReady = chk;
    e.ready = mReady; e.locked = mLocked; e.wordCnt = mWord; e.errCnt = mErr;
`ifdef SEQ_CHK_ERR_CAPTURE_EN
    e.fExp = mCapExp; e.fRcv = mCapRcv;
`endif
    expQ.push_back(e);
    @(posedge sim_clk);
    #1;
    if (errFlg) errPulses++;
    if (lossFlg) lossPulses++;
    if (expQ.size() == 0) check("queueEmpty", 64'(expQ.size()), 64'd1);
    else compareAll(expQ.pop_front());
  endtask

  task automatic clearAll();
    step(1'b0, '0, 1'b1, 1'b1);
    errPulses = 0; lossPulses = 0;
  endtask

  initial begin
    rstn = 1'b0; chkEn = 1'b0; clr = 1'b0; dataEn = 1'b0; data = '0;
    modelZero(1'b0);
    @(posedge sim_clk); #1;
    compareAll('0);
    rstn = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);

    // 1: clean stream 0..999
    errPulses = 0;
    for (int i = 0; i < 1000; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    check("t1_wordCnt", 64'(wordCnt), 64'd1000);
    check("t1_errCnt", 64'(errCnt), 64'd0);
    check("t1_errPulses", 64'(errPulses), 64'd0);

    // 2: one dropped word
    clearAll();
    for (int i = 0; i <= 100; i++) if (i != 50) step(1'b1, DW'(i), 1'b0, 1'b1);
    check("t2_errPulses", 64'(errPulses), 64'd1);
    check("t2_errCnt", 64'(errCnt), 64'd1);
    check("t2_wordCnt", 64'(wordCnt), 64'd100);
    check("t2_locked", 64'(locked), 64'd1);

    // 3: wrap through zero
    clearAll();
    for (int i = 0; i < 6; i++) step(1'b1, DW'(32'hFFFF_FFFE + i), 1'b0, 1'b1);
    check("t3_errCnt", 64'(errCnt), 64'd0);
    check("t3_wordCnt", 64'(wordCnt), 64'd6);

    // 4: loss of lock after LOSS consecutive mismatches, then relock
    clearAll();
    for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    step(1'b1, DW'(100), 1'b0, 1'b1);
    step(1'b1, DW'(7), 1'b0, 1'b1);
    step(1'b1, DW'(300), 1'b0, 1'b1);
    check("t4_lockedBefore", 64'(locked), 64'd1);
    step(1'b1, DW'(5), 1'b0, 1'b1);
    check("t4_lossFlg", 64'(lossFlg), 64'd1);
    check("t4_errPulses", 64'(errPulses), 64'd4);
    check("t4_lossPulses", 64'(lossPulses), 64'd1);
    check("t4_locked", 64'(locked), 64'd0);
    check("t4_errCnt", 64'(errCnt), 64'd4);
    step(1'b1, DW'(77), 1'b0, 1'b1);
    check("t4_relock", 64'(locked), 64'd1);
    check("t4_relockWord", 64'(wordCnt), 64'd1);
    check("t4_errHeld", 64'(errCnt), 64'd4);

    // chkEn dropped mid-stream: one more word accepted, then held, then seamless resume
    clearAll();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    step(1'b1, DW'(5), 1'b0, 1'b0);
    step(1'b1, DW'(99), 1'b0, 1'b0);
    step(1'b1, DW'(98), 1'b0, 1'b1);
    step(1'b1, DW'(6), 1'b0, 1'b1);
    check("en_wordCnt", 64'(wordCnt), 64'd7);
    check("en_errCnt", 64'(errCnt), 64'd0);

    // 5: clear wins over a word in the same cycle
    step(1'b1, DW'(7), 1'b0, 1'b1);
    step(1'b1, DW'(8), 1'b1, 1'b1);
    check("t5_wordCnt", 64'(wordCnt), 64'd0);
    check("t5_locked", 64'(locked), 64'd0);
    step(1'b1, DW'(40), 1'b0, 1'b1);
    check("t5_newLockWord", 64'(wordCnt), 64'd1);

    // 6: first-error capture, then async reset mid-stream
    clearAll();
    step(1'b1, DW'(0), 1'b0, 1'b1);
    step(1'b1, DW'(1), 1'b0, 1'b1);
    step(1'b1, DW'(2), 1'b0, 1'b1);
    step(1'b1, DW'(9), 1'b0, 1'b1);
    step(1'b1, DW'(10), 1'b0, 1'b1);
    step(1'b1, DW'(20), 1'b0, 1'b1);
    check("t6_errCnt", 64'(errCnt), 64'd2);
`ifdef SEQ_CHK_ERR_CAPTURE_EN
    check("t6_fExp", 64'(firstErrExp), 64'd3);
    check("t6_fRcv", 64'(firstErrRcv), 64'd9);
`else
    check("t6_fExpTied", 64'(firstErrExp), 64'd0);
    check("t6_fRcvTied", 64'(firstErrRcv), 64'd0);
`endif
    #2 rstn = 1'b0;
    #1;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_ready", 64'(rReady), 64'd0);
    check("rst_wordCnt", 64'(wordCnt), 64'd0);
    check("rst_errCnt", 64'(errCnt), 64'd0);
    check("rst_fExp", 64'(firstErrExp), 64'd0);
    check("rst_fRcv", 64'(firstErrRcv), 64'd0);
    #1 rstn = 1'b1;
    modelZero(1'b0);
    step(1'b1, DW'(50), 1'b0, 1'b1);
    step(1'b1, DW'(51), 1'b0, 1'b1);
    check("post_rst_locked", 64'(locked), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
